instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage of the impostor_32 RV32I core: owns the PC and issues req/ack reads to instruction memory.
//  Presents fetched words to decode through a registered valid/stall slot; if_opcode drives mainController.Opcode.
//  Accepts branch/jal redirects and contains a one-entry skid buffer; sustains 1 instr/clk with zero-wait memory.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h0000_0000 PC loaded on reset
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     synchronous active-high reset
//  imem_req        out  1     fetch request
//  imem_addr       out  XLEN  fetch address; stable while imem_req=1 until ack
//  imem_ack        in   1     rdata valid this cycle; ack may coincide with req
//  imem_rdata      in   32    instruction word
//  redirect_valid  in   1     branch/jump taken (from EX)
//  redirect_pc     in   XLEN  redirect target
//  stall           in   1     decode cannot consume the output slot this cycle
//  if_valid        out  1     output slot holds a live instruction
//  if_pc           out  XLEN  PC of if_instr
//  if_instr        out  32    instruction
//  if_opcode       out  7     if_instr[6:0], to mainController
// BEHAVIOUR
//  Reset (sync, rst=1): pc=RESET_PC, state=S_REQ, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP),
//    skid cleared; imem_req forced 0 while rst=1. First request (addr=RESET_PC) in first cycle rst=0.
//  slot_free = !if_valid || !stall. Output consumed when if_valid && !stall -> if_valid clears unless reloaded.
//  imem_addr driven from req_addr register, captured on entry to S_REQ; never changes mid-request.
//  States: S_REQ (req=1, addr=pc), S_FULL (req=0, skid holds word), S_DISCARD (req=1, addr=stale req_addr).
//  S_REQ, ack:
//    redirect_valid: drop rdata; pc<=redirect_pc; if_valid<=0; stay S_REQ.
//    slot_free: if_instr<=rdata, if_pc<=pc, if_valid<=1; pc<=pc+4; stay S_REQ (back-to-back).
//    else: skid<=rdata, skid_pc<=pc; pc<=pc+4; -> S_FULL.
//  S_REQ, no ack:
//    redirect_valid: pc<=redirect_pc; if_valid<=0; -> S_DISCARD (old request still outstanding).
//    else: hold.
//  S_FULL:
//    redirect_valid: clear skid and if_valid; pc<=redirect_pc; -> S_REQ.
//    !stall: output<=skid, if_valid=1; -> S_REQ.
//  S_DISCARD: keep req with stale addr; ack -> drop rdata, -> S_REQ at pc.
//    Further redirect updates pc only.
//  Priorities: rst > redirect_valid > stall. Redirect always squashes both if_valid and the skid.
//  Latency: ack -> if_valid at next edge.
//  pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0).
//  Never: duplicated or dropped non-squashed instruction; two live words beyond output+skid.
// CONFIGURATION
//  FETCH_MISALIGN_EN defined:
//    adds output if_misalign (1b, reset 0); redirect_pc[1:0]!=0 sets if_misalign=1, if_valid=1,
//    if_pc=redirect_pc, if_instr=NOP; no fetch issued; state S_FULL-like hold until !stall, then
//    req stays low until next redirect.
//  Undefined: port absent; redirect_pc[1:0] ignored (forced 2'b00).
// TESTING
//  Reset, ack same cycle, stall=0 -> if_pc 0x0,0x4,0x8 on successive cycles; if_opcode tracks rdata[6:0].
//  stall=1 with if_valid=1, ack at pc 0x8 -> skid; imem_req=0.
//    Release stall -> if_pc 0x8 next cycle, no loss/duplicate.
//  Ack delayed 3 cycles -> imem_addr stable 0xC throughout; if_valid=1 one cycle after ack.
//  Redirect to 0x100 while req pending -> S_DISCARD.
//    Stale ack dropped; next req addr 0x100; first if_pc 0x100.
//  Redirect, ack and stall in same cycle -> rdata dropped, if_valid=0, next imem_addr=redirect_pc.
//  rst asserted mid-S_FULL -> if_valid=0, if_instr=0x13, first post-reset req addr=RESET_PC.
//  FETCH_MISALIGN_EN only: redirect to 0x102 -> if_misalign=1, if_pc=0x102, imem_req=0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//  Instruction-memory read bus between the fetch stage and instruction memory.
//  req/addr issue a read; ack marks rdata valid (ack may coincide with req).
//  Ports (modports):
//    master (fetch)  : out req, addr   in  ack, rdata
//    slave  (memory) : in  req, addr   out ack, rdata
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            ack;
   logic [31:0]     rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//  Fetch stage of the impostor_32 RV32I core. Owns the PC, issues req/ack
//  reads to instruction memory and presents fetched words to decode through
//  a registered valid/stall output slot backed by a one-entry skid buffer.
//  Accepts branch/jal redirects; sustains 1 instr/clk with zero-wait memory.
//
//  Ports:
//    clk, rst        clock, synchronous active-high reset
//    imem            instr_fetch_if.master (req, addr, ack, rdata)
//    redirect_valid  taken branch/jump from EX
//    redirect_pc     redirect target
//    stall           decode cannot consume the output slot this cycle
//    if_valid        output slot holds a live instruction
//    if_pc, if_instr PC and word of the output slot
//    if_opcode       if_instr[6:0], to mainController
//    if_misalign     (FETCH_MISALIGN_EN only) slot carries a misaligned-target fault
//
//  Configuration macro: FETCH_MISALIGN_EN
//    defined   : misaligned redirect targets raise if_misalign and halt fetch
//                until the next redirect.
//    undefined : redirect_pc[1:0] is ignored (treated as 2'b00).
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_fetch_if.master        imem,
   input  logic                 redirect_valid,
   input  logic [XLEN-1:0]      redirect_pc,
   input  logic                 stall,
   output logic                 if_valid,
   output logic [XLEN-1:0]      if_pc,
   output logic [31:0]          if_instr,
   output logic [6:0]           if_opcode
`ifdef FETCH_MISALIGN_EN
   ,
   output logic                 if_misalign
`endif
);

   localparam logic [31:0]     NOP     = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,   // request outstanding at req_addr (== pc)
      S_FULL    = 2'd1,   // skid holds a word, no request
      S_DISCARD = 2'd2,   // squashed request still outstanding at stale req_addr
      S_HALT    = 2'd3    // misaligned target: no fetch until next redirect
   } state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] req_addr;
   logic [31:0]     skid_instr;
   logic [XLEN-1:0] skid_pc;

   logic            slot_free;
   logic            load_mem, load_skid, fill_skid, squash;
   logic [XLEN-1:0] redir_tgt;
   logic            redir_mis;
   state_t          redir_state;

`ifdef FETCH_MISALIGN_EN
   assign redir_tgt = redirect_pc;
   assign redir_mis = (redirect_pc[1:0] != 2'b00);
`else
   assign redir_tgt = redirect_pc & ~XLEN'(3);
   assign redir_mis = 1'b0;
`endif

   assign redir_state = redir_mis ? S_HALT : S_REQ;
   assign slot_free   = !if_valid || !stall;

   // ---- FSM state register ----
   always_ff @(posedge clk) begin
      if (rst) state <= S_REQ;
      else     state <= state_nxt;
   end

   // ---- FSM next state and datapath controls ----
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      load_mem  = 1'b0;
      load_skid = 1'b0;
      fill_skid = 1'b0;
      squash    = 1'b0;
      case (state)
         S_REQ: begin
            if (imem.ack) begin
               if (redirect_valid) begin
                  pc_nxt    = redir_tgt;
                  squash    = 1'b1;
                  state_nxt = redir_state;
               end else if (slot_free) begin
                  load_mem = 1'b1;
                  pc_nxt   = pc + PC_STEP;
               end else begin
                  fill_skid = 1'b1;
                  pc_nxt    = pc + PC_STEP;
                  state_nxt = S_FULL;
               end
            end else if (redirect_valid) begin
               // the old request must still complete before a new one starts
               pc_nxt    = redir_tgt;
               squash    = 1'b1;
               state_nxt = S_DISCARD;
            end
         end
         S_FULL: begin
            if (redirect_valid) begin
               pc_nxt    = redir_tgt;
               squash    = 1'b1;
               state_nxt = redir_state;
            end else if (!stall) begin
               load_skid = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_DISCARD: begin
            if (redirect_valid) begin
               pc_nxt = redir_tgt;
               squash = 1'b1;
            end
            // pc_nxt already reflects a same-cycle redirect
            if (imem.ack) begin
               state_nxt = (pc_nxt[1:0] != 2'b00) ? S_HALT : S_REQ;
            end
         end
         S_HALT: begin
            if (redirect_valid) begin
               pc_nxt    = redir_tgt;
               squash    = 1'b1;
               state_nxt = redir_state;
            end
         end
         default: state_nxt = S_REQ;
      endcase
   end

   // ---- FSM outputs ----
   always_comb begin
      imem.req = !rst && ((state == S_REQ) || (state == S_DISCARD));
   end

   assign imem.addr = req_addr;
   assign if_opcode = if_instr[6:0];

   // ---- output slot, skid and PC registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_instr <= NOP;
`ifdef FETCH_MISALIGN_EN
         if_misalign <= 1'b0;
`endif
      end else begin
         pc <= pc_nxt;
         if (state_nxt == S_REQ) req_addr <= pc_nxt;

         if (if_valid && !stall) begin
            if_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            if_misalign <= 1'b0;
`endif
         end
         if (load_mem) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= imem.rdata;
         end
         if (load_skid) begin
            if_valid <= 1'b1;
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
         end
         if (fill_skid) begin
            skid_instr <= imem.rdata;
            skid_pc    <= pc;
         end
         if (squash) begin
            if_valid <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            if_misalign <= 1'b0;
            if (redir_mis) begin
               if_valid    <= 1'b1;
               if_pc       <= redirect_pc;
               if_instr    <= NOP;
               if_misalign <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//  Directed bench for instr_fetch. Memory returns mem_word(addr) whenever the
//  bench raises ack; expected values are hand-derived in the step sequence.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [6:0]  if_opcode;
`ifdef FETCH_MISALIGN_EN
   logic        if_misalign;
`endif

   int nchk  = 0;
   int nfail = 0;

   instr_fetch_if #(.XLEN(32)) imem ();

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_opcode      (if_opcode)
`ifdef FETCH_MISALIGN_EN
      ,
      .if_misalign    (if_misalign)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[24:0], a[8:2] ^ 7'h33};
   endfunction

   assign imem.rdata = mem_word(imem.addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      logic [31:0] w;
      rst            = 1'b1;
      imem.ack       = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      tick();
      tick();
      check("rst_req",    {31'd0, imem.req}, 32'd0);
      check("rst_valid",  {31'd0, if_valid}, 32'd0);
      check("rst_instr",  if_instr, 32'h0000_0013);
      check("rst_pc",     if_pc, 32'h0);
      check("rst_opcode", {25'd0, if_opcode}, 32'h13);

      // first request in first cycle out of reset
      rst = 1'b0;
      #1;
      check("first_req",  {31'd0, imem.req}, 32'd1);
      check("first_addr", imem.addr, 32'h0);

      // back-to-back zero-wait fetch
      imem.ack = 1'b1;
      tick();
      w = mem_word(32'h0);
      check("b2b0_valid",  {31'd0, if_valid}, 32'd1);
      check("b2b0_pc",     if_pc, 32'h0);
      check("b2b0_instr",  if_instr, w);
      check("b2b0_opcode", {25'd0, if_opcode}, {25'd0, w[6:0]});
      check("b2b0_addr",   imem.addr, 32'h4);
      tick();
      w = mem_word(32'h4);
      check("b2b1_pc",     if_pc, 32'h4);
      check("b2b1_opcode", {25'd0, if_opcode}, {25'd0, w[6:0]});
      check("b2b1_addr",   imem.addr, 32'h8);

      // stall with live output: word at 0x8 goes to skid
      stall = 1'b1;
      tick();
      check("skid_pc",    if_pc, 32'h4);
      check("skid_valid", {31'd0, if_valid}, 32'd1);
      check("skid_req",   {31'd0, imem.req}, 32'd0);
      imem.ack = 1'b0;
      tick();
      check("skid_hold_pc",  if_pc, 32'h4);
      check("skid_hold_req", {31'd0, imem.req}, 32'd0);
      stall = 1'b0;
      tick();
      check("unskid_pc",    if_pc, 32'h8);
      check("unskid_instr", if_instr, mem_word(32'h8));
      check("unskid_req",   {31'd0, imem.req}, 32'd1);
      check("unskid_addr",  imem.addr, 32'hC);

      // ack delayed three cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wait_addr",  imem.addr, 32'hC);
         check("wait_req",   {31'd0, imem.req}, 32'd1);
         check("wait_valid", {31'd0, if_valid}, 32'd0);
      end
      imem.ack = 1'b1;
      tick();
      check("late_valid", {31'd0, if_valid}, 32'd1);
      check("late_pc",    if_pc, 32'hC);
      check("late_addr",  imem.addr, 32'h10);

      // redirect while request pending -> discard stale response
      imem.ack       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      check("disc_valid", {31'd0, if_valid}, 32'd0);
      check("disc_req",   {31'd0, imem.req}, 32'd1);
      check("disc_addr",  imem.addr, 32'h10);
      redirect_valid = 1'b0;
      tick();
      check("disc_addr2", imem.addr, 32'h10);
      imem.ack = 1'b1;
      tick();
      check("disc_drop_valid", {31'd0, if_valid}, 32'd0);
      check("disc_new_addr",   imem.addr, 32'h100);
      tick();
      check("redir_valid", {31'd0, if_valid}, 32'd1);
      check("redir_pc",    if_pc, 32'h100);
      check("redir_instr", if_instr, mem_word(32'h100));
      check("redir_addr",  imem.addr, 32'h104);

      // redirect, ack and stall together
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      check("ras_valid", {31'd0, if_valid}, 32'd0);
      check("ras_addr",  imem.addr, 32'h200);
      check("ras_req",   {31'd0, imem.req}, 32'd1);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      tick();
      check("ras_pc",    if_pc, 32'h200);
      check("ras_addr2", imem.addr, 32'h204);

      // misaligned redirect target
      redirect_valid = 1'b1;
      redirect_pc    = 32'h302;
`ifdef FETCH_MISALIGN_EN
      tick();
      check("mis_flag",  {31'd0, if_misalign}, 32'd1);
      check("mis_valid", {31'd0, if_valid}, 32'd1);
      check("mis_pc",    if_pc, 32'h302);
      check("mis_instr", if_instr, 32'h13);
      check("mis_req",   {31'd0, imem.req}, 32'd0);
      redirect_valid = 1'b0;
      stall          = 1'b1;
      tick();
      check("mis_hold_valid", {31'd0, if_valid}, 32'd1);
      check("mis_hold_req",   {31'd0, imem.req}, 32'd0);
      stall = 1'b0;
      tick();
      check("mis_done_valid", {31'd0, if_valid}, 32'd0);
      check("mis_done_req",   {31'd0, imem.req}, 32'd0);
      check("mis_done_flag",  {31'd0, if_misalign}, 32'd0);
      imem.ack       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      check("mis_exit_addr", imem.addr, 32'h300);
      check("mis_exit_req",  {31'd0, imem.req}, 32'd1);
      redirect_valid = 1'b0;
      imem.ack       = 1'b1;
`else
      tick();
      check("align_valid", {31'd0, if_valid}, 32'd0);
      check("align_addr",  imem.addr, 32'h300);
      redirect_valid = 1'b0;
`endif
      tick();
      check("post_mis_pc",    if_pc, 32'h300);
      check("post_mis_instr", if_instr, mem_word(32'h300));
      check("post_mis_addr",  imem.addr, 32'h304);

      // PC wrap at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      check("wrap_addr0", imem.addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      tick();
      check("wrap_pc0",   if_pc, 32'hFFFF_FFFC);
      check("wrap_addr1", imem.addr, 32'h0);
      tick();
      check("wrap_pc1",    if_pc, 32'h0);
      check("wrap_instr1", if_instr, mem_word(32'h0));
      check("wrap_addr2",  imem.addr, 32'h4);

      // reset while the skid is full
      stall = 1'b1;
      tick();
      check("full_req", {31'd0, imem.req}, 32'd0);
      imem.ack = 1'b0;
      rst      = 1'b1;
      #1;
      check("rst_mid_req", {31'd0, imem.req}, 32'd0);
      tick();
      check("rst_mid_valid", {31'd0, if_valid}, 32'd0);
      check("rst_mid_instr", if_instr, 32'h13);
      check("rst_mid_pc",    if_pc, 32'h0);
      stall = 1'b0;
      rst   = 1'b0;
      #1;
      check("post_rst_req",  {31'd0, imem.req}, 32'd1);
      check("post_rst_addr", imem.addr, 32'h0);
      imem.ack = 1'b1;
      tick();
      check("post_rst_valid", {31'd0, if_valid}, 32'd1);
      check("post_rst_pc",    if_pc, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
